// File: rtl/simd_booth_lane_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// booth_simd_pkg
// Shared types and constants for the SIMD Booth lane sequencer.
//   - mode_e  : lane-split encodings (1x16, 2x8, 4x4, illegal)
//   - state_e : sequencer FSM states
//   - lane width / lane count / lane stride / step count per mode
//   - accumulator, operand and product widths
//   - last_step(): counter value at which the final Booth step is taken
// ---------------------------------------------------------------------------
package booth_simd_pkg;

    localparam int OP_W   = 16;
    localparam int ACC_W  = 36;
    localparam int PROD_W = 32;
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        MODE_16      = 2'b00,
        MODE_8       = 2'b01,
        MODE_4       = 2'b10,
        MODE_ILLEGAL = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Lane width n, lane count L, lane stride 2n+1 (A, Q and Q-1 bits).
    localparam int LANE_W_16 = 16;
    localparam int LANE_W_8  = 8;
    localparam int LANE_W_4  = 4;
    localparam int LANES_16  = 1;
    localparam int LANES_8   = 2;
    localparam int LANES_4   = 4;
    localparam int STRIDE_16 = 2 * LANE_W_16 + 1;
    localparam int STRIDE_8  = 2 * LANE_W_8 + 1;
    localparam int STRIDE_4  = 2 * LANE_W_4 + 1;

    // One Booth step per multiplier bit.
    localparam int STEPS_16 = LANE_W_16;
    localparam int STEPS_8  = LANE_W_8;
    localparam int STEPS_4  = LANE_W_4;

    // The counter is cleared at start, so the final step is taken when it
    // holds steps-1.
    function automatic logic [CNT_W-1:0] last_step(input mode_e mode);
        case (mode)
            MODE_8:  last_step = CNT_W'(STEPS_8 - 1);
            MODE_4:  last_step = CNT_W'(STEPS_4 - 1);
            default: last_step = CNT_W'(STEPS_16 - 1);
        endcase
    endfunction

endpackage

// File: rtl/simd_booth_lane_sequencer_if.sv
// ---------------------------------------------------------------------------
// simd_booth_lane_sequencer_if
// Bundles the request, shifter and product-handshake signals of the
// sequencer.
//   start/mode/multiplicand/multiplier : operation request (master -> slave)
//   busy                               : sequencer not idle
//   z_out/sum_out/mode_out             : to external arithmetic shifter
//   shifted_in                         : shifter result, next accumulator
//   prod_valid/prod_ready/product      : valid/ready product port
// slave  = the sequencer, master = the requester / shifter / consumer side.
// ---------------------------------------------------------------------------
interface simd_booth_lane_sequencer_if;
    import booth_simd_pkg::*;

    logic              start;
    logic [1:0]        mode;
    logic [OP_W-1:0]   multiplicand;
    logic [OP_W-1:0]   multiplier;
    logic              busy;
    logic [ACC_W-1:0]  z_out;
    logic [OP_W-1:0]   sum_out;
    logic [1:0]        mode_out;
    logic [ACC_W-1:0]  shifted_in;
    logic              prod_valid;
    logic              prod_ready;
    logic [PROD_W-1:0] product;

    modport slave (
        input  start, mode, multiplicand, multiplier, shifted_in, prod_ready,
        output busy, z_out, sum_out, mode_out, prod_valid, product
    );

    modport master (
        output start, mode, multiplicand, multiplier, shifted_in, prod_ready,
        input  busy, z_out, sum_out, mode_out, prod_valid, product
    );

endinterface

// File: rtl/simd_booth_lane_sequencer_lane_adder.sv
// ---------------------------------------------------------------------------
// booth_lane_adder
// Combinational per-lane Booth add/subtract.
//   i_z    : packed accumulator; per lane Q-1 = Z[b], Q = Z[b+n:b+1],
//            A = Z[b+2n:b+n+1], b = k*(2n+1)
//   i_m    : packed signed multiplicand lanes, lane k at [k*n+n-1 : k*n]
//   i_mode : lane split
//   o_sum  : packed n-bit lane sums (A+M, A-M or A), lane k at
//            [k*n+n-1 : k*n]; each lane wraps on its own, no carry crosses
// ---------------------------------------------------------------------------
module booth_lane_adder
    import booth_simd_pkg::*;
(
    input  logic [ACC_W-1:0] i_z,
    input  logic [OP_W-1:0]  i_m,
    input  mode_e            i_mode,
    output logic [OP_W-1:0]  o_sum
);

    logic [OP_W-1:0] w_sum16;
    logic [OP_W-1:0] w_sum8;
    logic [OP_W-1:0] w_sum4;

    // Pair (Q0, Q-1): 01 adds M, 10 subtracts M, 00/11 passes A through.
    // Each lane is computed at its own width, which is what keeps lane
    // carries from leaking into the neighbour.
    for (genvar k = 0; k < LANES_16; k++) begin : g_lane16
        localparam int B = k * STRIDE_16;
        logic [1:0]           w_pair;
        logic [LANE_W_16-1:0] w_a;
        logic [LANE_W_16-1:0] w_m;
        assign w_pair = i_z[B+1:B];
        assign w_a    = i_z[B+2*LANE_W_16:B+LANE_W_16+1];
        assign w_m    = i_m[k*LANE_W_16 +: LANE_W_16];
        assign w_sum16[k*LANE_W_16 +: LANE_W_16] =
            (w_pair == 2'b01) ? w_a + w_m :
            (w_pair == 2'b10) ? w_a - w_m : w_a;
    end

    for (genvar k = 0; k < LANES_8; k++) begin : g_lane8
        localparam int B = k * STRIDE_8;
        logic [1:0]          w_pair;
        logic [LANE_W_8-1:0] w_a;
        logic [LANE_W_8-1:0] w_m;
        assign w_pair = i_z[B+1:B];
        assign w_a    = i_z[B+2*LANE_W_8:B+LANE_W_8+1];
        assign w_m    = i_m[k*LANE_W_8 +: LANE_W_8];
        assign w_sum8[k*LANE_W_8 +: LANE_W_8] =
            (w_pair == 2'b01) ? w_a + w_m :
            (w_pair == 2'b10) ? w_a - w_m : w_a;
    end

    for (genvar k = 0; k < LANES_4; k++) begin : g_lane4
        localparam int B = k * STRIDE_4;
        logic [1:0]          w_pair;
        logic [LANE_W_4-1:0] w_a;
        logic [LANE_W_4-1:0] w_m;
        assign w_pair = i_z[B+1:B];
        assign w_a    = i_z[B+2*LANE_W_4:B+LANE_W_4+1];
        assign w_m    = i_m[k*LANE_W_4 +: LANE_W_4];
        assign w_sum4[k*LANE_W_4 +: LANE_W_4] =
            (w_pair == 2'b01) ? w_a + w_m :
            (w_pair == 2'b10) ? w_a - w_m : w_a;
    end

    // NOTE: every always_comb output gets a default first so no path
    // through the case leaves it unassigned, which would infer a latch.
    always_comb begin
        o_sum = '0;
        case (i_mode)
            MODE_16: o_sum = w_sum16;
            MODE_8:  o_sum = w_sum8;
            MODE_4:  o_sum = w_sum4;
            default: o_sum = '0;
        endcase
    end

endmodule

// File: rtl/simd_booth_lane_sequencer.sv
// ---------------------------------------------------------------------------
// simd_booth_lane_sequencer
// Sequencing / accumulator half of the SIMD Booth multiplier. Holds the
// packed 36-bit accumulator Z, produces per-lane A+-M sums for the external
// arithmetic shifter, registers the shifter result each step and, after n
// steps, presents the packed lane products on a valid/ready port.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : simd_booth_lane_sequencer_if.slave (request, shifter, product)
// ---------------------------------------------------------------------------
module simd_booth_lane_sequencer
    import booth_simd_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    simd_booth_lane_sequencer_if.slave bus
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [ACC_W-1:0] r_z;
    logic [OP_W-1:0]  r_m;
    mode_e            r_mode;
    logic [CNT_W-1:0] r_cnt;

    mode_e             w_mode_in;
    logic              w_accept;
    logic              w_last;
    logic [ACC_W-1:0]  w_load_z;
    logic [OP_W-1:0]   w_sum;
    logic [PROD_W-1:0] w_prod;
    logic [OP_W-1:0]   w_q;

    assign w_mode_in = mode_e'(bus.mode);
    assign w_q       = bus.multiplier;
    assign w_accept  = (r_state == ST_IDLE) && bus.start && (w_mode_in != MODE_ILLEGAL);
    assign w_last    = (r_cnt == last_step(r_mode));

    // Initial accumulator: per lane A = 0, Q = multiplier lane, Q-1 = 0.
    always_comb begin
        w_load_z = '0;
        case (w_mode_in)
            MODE_8: w_load_z = {2'b00,
                                8'h00, w_q[15:8], 1'b0,
                                8'h00, w_q[7:0],  1'b0};
            MODE_4: w_load_z = {4'h0, w_q[15:12], 1'b0,
                                4'h0, w_q[11:8],  1'b0,
                                4'h0, w_q[7:4],   1'b0,
                                4'h0, w_q[3:0],   1'b0};
            default: w_load_z = {3'b000, 16'h0000, w_q, 1'b0};
        endcase
    end

    // Product lane k is {A,Q} = Z[b+2n : b+1]; the Q-1 bit of each lane
    // is dropped.
    always_comb begin
        w_prod = '0;
        case (r_mode)
            MODE_8: w_prod = {r_z[33:18], r_z[16:1]};
            MODE_4: w_prod = {r_z[35:28], r_z[26:19], r_z[17:10], r_z[8:1]};
            default: w_prod = r_z[32:1];
        endcase
    end

    booth_lane_adder u_lane_adder (
        .i_z    (r_z),
        .i_m    (r_m),
        .i_mode (r_mode),
        .o_sum  (w_sum)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)        w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last)          w_state_nxt = ST_DONE;
            ST_DONE: if (bus.prod_ready)  w_state_nxt = ST_IDLE;
            default:                      w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath registers. Z holds in IDLE (after an ignored start) and in
    // DONE while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_z    <= '0;
            r_m    <= '0;
            r_mode <= MODE_16;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_z    <= w_load_z;
                        r_m    <= bus.multiplicand;
                        r_mode <= w_mode_in;
                        r_cnt  <= '0;
                    end
                end
                ST_RUN: begin
                    r_z   <= bus.shifted_in;
                    r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.z_out      = r_z;
    assign bus.mode_out   = r_mode;
    assign bus.sum_out    = (r_state == ST_RUN)  ? w_sum  : '0;
    assign bus.prod_valid = (r_state == ST_DONE);
    assign bus.product    = (r_state == ST_DONE) ? w_prod : '0;

endmodule

// File: tb/tb_simd_booth_lane_sequencer.sv
// ---------------------------------------------------------------------------
// tb_simd_booth_lane_sequencer
// Directed bench for simd_booth_lane_sequencer. Models the external
// arithmetic shifter (per lane {sum, Q, Q-1} >>> 1) and checks products,
// latency, backpressure, illegal mode and mid-run reset against
// hand-computed values.
// ---------------------------------------------------------------------------
module tb_simd_booth_lane_sequencer;
    import booth_simd_pkg::*;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    simd_booth_lane_sequencer_if bus ();

    simd_booth_lane_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shifter model: lane becomes {sum[n-1], sum, Q}, i.e. the arithmetic
    // right shift of {sum, Q, Q-1}.
    always_comb begin
        bus.shifted_in = '0;
        case (bus.mode_out)
            2'b01: begin
                for (int k = 0; k < 2; k++)
                    bus.shifted_in[k*17 +: 17] = {bus.sum_out[k*8+7], bus.sum_out[k*8 +: 8],
                                                  bus.z_out[k*17+1 +: 8]};
            end
            2'b10: begin
                for (int k = 0; k < 4; k++)
                    bus.shifted_in[k*9 +: 9] = {bus.sum_out[k*4+3], bus.sum_out[k*4 +: 4],
                                                bus.z_out[k*9+1 +: 4]};
            end
            default: bus.shifted_in[32:0] = {bus.sum_out[15], bus.sum_out, bus.z_out[16:1]};
        endcase
    end

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a start, wait for prod_valid and check latency and product.
    // Leaves the DUT in DONE.
    task automatic run_to_done(input string tag, input logic [1:0] md,
                               input logic [15:0] mc, input logic [15:0] mq,
                               input int exp_cyc, input logic [31:0] exp_p);
        int cyc;
        bus.start        = 1'b1;
        bus.mode         = md;
        bus.multiplicand = mc;
        bus.multiplier   = mq;
        tick();
        bus.start = 1'b0;
        check({tag, "_busy"}, 36'(bus.busy), 36'd1);
        check({tag, "_mode_out"}, 36'(bus.mode_out), 36'(md));
        cyc = 0;
        while (!bus.prod_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, 36'(cyc), 36'(exp_cyc));
        check({tag, "_product"}, 36'(bus.product), 36'(exp_p));
    endtask

    task automatic release_product(input string tag);
        bus.prod_ready = 1'b1;
        tick();
        bus.prod_ready = 1'b0;
        check({tag, "_idle_busy"}, 36'(bus.busy), 36'd0);
        check({tag, "_idle_valid"}, 36'(bus.prod_valid), 36'd0);
        check({tag, "_idle_product"}, 36'(bus.product), 36'd0);
    endtask

    initial begin
        int hits;
        n_total          = 0;
        n_bad            = 0;
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.mode         = 2'b00;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        bus.prod_ready   = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state.
        check("rst_busy", 36'(bus.busy), 36'd0);
        check("rst_z", bus.z_out, 36'd0);
        check("rst_mode_out", 36'(bus.mode_out), 36'd0);
        check("rst_valid", 36'(bus.prod_valid), 36'd0);
        check("rst_product", 36'(bus.product), 36'd0);
        check("rst_sum", 36'(bus.sum_out), 36'd0);

        // Illegal mode: nothing loads, nothing starts.
        bus.start        = 1'b1;
        bus.mode         = 2'b11;
        bus.multiplicand = 16'h1234;
        bus.multiplier   = 16'hABCD;
        tick();
        bus.start = 1'b0;
        check("ill_busy", 36'(bus.busy), 36'd0);
        check("ill_z", bus.z_out, 36'd0);
        check("ill_mode_out", 36'(bus.mode_out), 36'd0);
        tick();
        check("ill_busy2", 36'(bus.busy), 36'd0);

        // Mode 00: 3 * -5 = -15. First step has pair 10, so sum = 0 - 3.
        bus.start        = 1'b1;
        bus.mode         = 2'b00;
        bus.multiplicand = 16'h0003;
        bus.multiplier   = 16'hFFFB;
        tick();
        bus.start = 1'b0;
        check("m16_load_z", bus.z_out, 36'h0_0001_FFF6);
        check("m16_first_sum", 36'(bus.sum_out), 36'h0FFFD);
        begin
            int cyc;
            cyc = 0;
            while (!bus.prod_valid && cyc < 100) begin
                tick();
                cyc++;
            end
            check("m16_latency", 36'(cyc), 36'd16);
        end
        check("m16_product", 36'(bus.product), 36'hFFFFFFF1);
        check("m16_z_done", bus.z_out, 36'h1_FFFF_FFE3);
        check("m16_sum_done", 36'(bus.sum_out), 36'd0);
        release_product("m16");

        // Mode 01: lanes 127*2 and -7*9.
        run_to_done("m8", 2'b01, 16'h7FF9, 16'h0209, 8, 32'h00FEFFC1);
        release_product("m8");

        // Mode 10: lanes 7*7, 3*-3, -1*5, 2*0.
        run_to_done("m4", 2'b10, 16'h73F2, 16'h7D50, 4, 32'h31F7FB00);
        release_product("m4");

        // Backpressure: hold DONE, pulse start, product must stay put.
        run_to_done("bp", 2'b10, 16'h73F2, 16'h7D50, 4, 32'h31F7FB00);
        bus.start        = 1'b1;
        bus.mode         = 2'b00;
        bus.multiplicand = 16'h0001;
        bus.multiplier   = 16'h0001;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_product", 36'(bus.product), 36'h31F7FB00);
            check("bp_hold_busy", 36'(bus.busy), 36'd1);
            check("bp_hold_mode", 36'(bus.mode_out), 36'd2);
        end
        bus.start = 1'b0;
        release_product("bp");
        tick();
        check("bp_stay_idle", 36'(bus.busy), 36'd0);

        // Reset mid-run at step 3 of a mode 00 run.
        bus.start        = 1'b1;
        bus.mode         = 2'b00;
        bus.multiplicand = 16'h0003;
        bus.multiplier   = 16'hFFFB;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_busy", 36'(bus.busy), 36'd0);
        check("mrst_z", bus.z_out, 36'd0);
        check("mrst_mode_out", 36'(bus.mode_out), 36'd0);
        check("mrst_valid", 36'(bus.prod_valid), 36'd0);
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.prod_valid) hits++;
        end
        check("mrst_no_valid", 36'(hits), 36'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
